// File: rtl/sram_xbar_n_if.sv
// Bus bundle between the pipeline data port, the crossbar and its N SRAM-style slaves.
// The crossbar takes the slave modport; the environment driving it takes the master modport.
interface sram_xbar_n_if #(
    parameter int unsigned LEN_ADDR = 64,
    parameter int unsigned LEN_DATA = 64,
    parameter int unsigned N_SLAVE  = 4
);
    logic [LEN_ADDR-1:0]            master_addra;
    logic [LEN_DATA-1:0]            master_dina;
    logic [LEN_DATA-1:0]            master_douta;
    logic                           master_ena;
    logic [LEN_DATA/8-1:0]          master_wea;
    logic [N_SLAVE*LEN_ADDR-1:0]    slave_addra;
    logic [N_SLAVE*LEN_DATA-1:0]    slave_dina;
    logic [N_SLAVE*LEN_DATA-1:0]    slave_douta;
    logic [N_SLAVE-1:0]             slave_ena;
    logic [N_SLAVE*LEN_DATA/8-1:0]  slave_wea;

    modport slave (
        input  master_addra, master_dina, master_ena, master_wea, slave_douta,
        output master_douta, slave_addra, slave_dina, slave_ena, slave_wea
    );

    modport master (
        output master_addra, master_dina, master_ena, master_wea, slave_douta,
        input  master_douta, slave_addra, slave_dina, slave_ena, slave_wea
    );
endinterface

// File: rtl/sram_xbar_n.sv
// 1-master / N-slave SRAM-style interconnect: base/mask decode with lowest-index priority,
// registered response select matching 1-cycle read latency, sticky decode-miss reporting.
module sram_xbar_n #(
    parameter int unsigned                LEN_ADDR      = 64,
    parameter int unsigned                LEN_DATA      = 64,
    parameter int unsigned                N_SLAVE       = 4,
    parameter logic [N_SLAVE*LEN_ADDR-1:0] SLAVE_BASE   = '0,
    parameter logic [N_SLAVE*LEN_ADDR-1:0] SLAVE_MASK   = '0,
    parameter logic [LEN_DATA-1:0]        DEFAULT_RDATA = '1
) (
    input  logic                clk,
    input  logic                rst,
    sram_xbar_n_if.slave        bus,
    input  logic                err_clr,
    output logic                decode_err,
    output logic [LEN_ADDR-1:0] err_addr,
    output logic [7:0]          err_count
);
    localparam int unsigned LEN_STRB = LEN_DATA / 8;
    localparam int unsigned LEN_SEL  = (N_SLAVE > 1) ? $clog2(N_SLAVE) : 1;

    logic [N_SLAVE-1:0]  hit_s;
    logic [LEN_SEL-1:0]  sel_s;
    logic                miss_s;
    logic                access_s;
    logic [LEN_DATA-1:0] douta_s;

    logic [LEN_SEL-1:0]  sel_d, sel_q;
    logic                miss_d, miss_q;
    logic                decode_err_d, decode_err_q;
    logic [LEN_ADDR-1:0] err_addr_d, err_addr_q;
    logic [7:0]          err_count_d, err_count_q;

    // Address decode: per-slave base/mask match, lowest index wins where regions overlap.
    always_comb begin
        hit_s = '0;
        sel_s = '0;
        for (int i = 0; i < N_SLAVE; i++) begin
            hit_s[i] = (bus.master_addra & SLAVE_MASK[i*LEN_ADDR +: LEN_ADDR]) ==
                       (SLAVE_BASE[i*LEN_ADDR +: LEN_ADDR] & SLAVE_MASK[i*LEN_ADDR +: LEN_ADDR]);
        end
        for (int i = N_SLAVE - 1; i >= 0; i--) begin
            if (hit_s[i]) begin
                sel_s = LEN_SEL'(i);
            end else begin
                sel_s = sel_s;
            end
        end
    end

    assign miss_s   = ~|hit_s;
    assign access_s = bus.master_ena & ~rst;

    // Request forwarding: broadcast address/data, steer enable and strobes to the selected slave only.
    always_comb begin
        bus.slave_addra = {N_SLAVE{bus.master_addra}};
        bus.slave_dina  = {N_SLAVE{bus.master_dina}};
        bus.slave_ena   = '0;
        bus.slave_wea   = '0;
        for (int i = 0; i < N_SLAVE; i++) begin
            if (access_s && !miss_s && (sel_s == LEN_SEL'(i))) begin
                bus.slave_ena[i]                      = 1'b1;
                bus.slave_wea[i*LEN_STRB +: LEN_STRB] = bus.master_wea;
            end else begin
                bus.slave_ena[i] = 1'b0;
            end
        end
    end

    // Next-state for the response select and the error bookkeeping; a miss outranks err_clr.
    always_comb begin
        sel_d        = sel_q;
        miss_d       = miss_q;
        decode_err_d = decode_err_q;
        err_addr_d   = err_addr_q;
        err_count_d  = err_count_q;
        if (bus.master_ena) begin
            sel_d  = sel_s;
            miss_d = miss_s;
        end else begin
            sel_d  = sel_q;
        end
        if (bus.master_ena && miss_s) begin
            decode_err_d = 1'b1;
            if (err_clr || !decode_err_q) begin
                err_addr_d = bus.master_addra;
            end else begin
                err_addr_d = err_addr_q;
            end
            if (err_clr) begin
                err_count_d = 8'd1;
            end else if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end else begin
                err_count_d = err_count_q;
            end
        end else if (err_clr) begin
            decode_err_d = 1'b0;
            err_addr_d   = '0;
            err_count_d  = 8'd0;
        end else begin
            decode_err_d = decode_err_q;
        end
    end

    // State registers; reset leaves the response path pointing at the miss value.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q        <= '0;
            miss_q       <= 1'b1;
            decode_err_q <= 1'b0;
            err_addr_q   <= '0;
            err_count_q  <= 8'd0;
        end else begin
            sel_q        <= sel_d;
            miss_q       <= miss_d;
            decode_err_q <= decode_err_d;
            err_addr_q   <= err_addr_d;
            err_count_q  <= err_count_d;
        end
    end

    // Response mux: holding sel_q keeps the last slave output visible, like an SRAM.
    always_comb begin
        douta_s = DEFAULT_RDATA;
        for (int i = 0; i < N_SLAVE; i++) begin
            if (!miss_q && (sel_q == LEN_SEL'(i))) begin
                douta_s = bus.slave_douta[i*LEN_DATA +: LEN_DATA];
            end else begin
                douta_s = douta_s;
            end
        end
    end

    assign bus.master_douta = douta_s;
    assign decode_err       = decode_err_q;
    assign err_addr         = err_addr_q;
    assign err_count        = err_count_q;
endmodule
